// File: rtl/nios_tx_bridge.sv
// Nios PIO toggle-handshake to ready/valid bridge with a show-ahead FIFO.
// Optional saturating drop counter enabled by defining NIOS_TX_BRIDGE_DROP_CNT_EN.
module nios_tx_bridge #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              in_port,
    output logic [30:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     clr_overflow
`ifdef NIOS_TX_BRIDGE_DROP_CNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_in_q;
    logic          r_tog_q;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_overflow;
    logic [30:0]   r_mem [DEPTH];

    logic w_push;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_drop;

    // A message is announced by flipping bit 31; payload-only changes are ignored.
    assign w_push  = r_in_q[31] ^ r_tog_q;
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_pop   = out_ready && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_q     <= '0;
            r_tog_q    <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_in_q  <= in_port;
            r_tog_q <= r_in_q[31];
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            // A drop on the same edge as a clear keeps the flag set.
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clr_overflow)
                r_overflow <= 1'b0;
        end
    end

    // Storage is not reset; the read side is gated by out_valid instead.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= r_in_q[30:0];
    end

    assign out_valid  = !w_empty;
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

`ifdef NIOS_TX_BRIDGE_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_drop_cnt <= '0;
        else if (w_drop)
            r_drop_cnt <= clr_overflow ? 8'd1 : sat_inc(r_drop_cnt);
        else if (clr_overflow)
            r_drop_cnt <= '0;
    end

    assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_nios_tx_bridge.sv
// Directed bench for nios_tx_bridge: scoreboard queue of expected payloads,
// immediate-assertion checks; drop-counter steps only when the macro is defined.
module tb_nios_tx_bridge;

    logic        clk;
    logic        reset_n;
    logic [31:0] in_port;
    logic [30:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        clr_overflow;
`ifdef NIOS_TX_BRIDGE_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    nios_tx_bridge #(.DEPTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_port      (in_port),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
`ifdef NIOS_TX_BRIDGE_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        tog    = 1'b0;
    logic [30:0] sb_q[$];

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flip the toggle with a new payload; the push lands two edges later.
    task automatic send(input logic [30:0] v);
        tog     = ~tog;
        in_port = {tog, v};
        tick();
    endtask

    // Pop one entry and compare it against the scoreboard head.
    task automatic pop_chk(input string tag);
        logic [30:0] exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 31'h0;
        chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        chk(tag, {1'b0, out_data}, {1'b0, exp});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        in_port      = 32'h0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        tick(2);
        chk("rst_level", {28'h0, fifo_level}, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_ovf",   {31'h0, overflow}, 32'h0);
        chk("rst_data",  {1'b0, out_data}, 32'h0);
        reset_n = 1'b1;
        tick(3);
        chk("no_spurious_push", {28'h0, fifo_level}, 32'h0);

        // Payload changes with bit 31 held low never push.
        in_port = 32'h0000_0005;
        tick();
        in_port = 32'h0000_0007;
        tick(3);
        chk("payload_only_level", {28'h0, fifo_level}, 32'h0);
        chk("payload_only_valid", {31'h0, out_valid}, 32'h0);

        // Single message: valid two edges after presentation.
        tog     = 1'b1;
        in_port = 32'h8000_00AB;
        sb_q.push_back(31'h00AB);
        tick();
        chk("single_lat1_valid", {31'h0, out_valid}, 32'h0);
        tick();
        chk("single_level", {28'h0, fifo_level}, 32'h1);
        tick(2);
        chk("single_hold_data", {1'b0, out_data}, 32'h00AB);
        pop_chk("single_data");
        chk("single_drained", {28'h0, fifo_level}, 32'h0);

        // Burst of 8 into an 8-deep FIFO.
        for (int i = 1; i <= 8; i++) begin
            send(31'(i));
            sb_q.push_back(31'(i));
        end
        tick(2);
        chk("burst_level", {28'h0, fifo_level}, 32'h8);
        chk("burst_ovf",   {31'h0, overflow}, 32'h0);

        // Push and pop on the same edge while full.
        tog     = ~tog;
        in_port = {tog, 31'h9};
        tick();
        chk("full_pp_head", {1'b0, out_data}, {1'b0, sb_q.pop_front()});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        sb_q.push_back(31'h9);
        chk("full_pp_level", {28'h0, fifo_level}, 32'h8);
        chk("full_pp_ovf",   {31'h0, overflow}, 32'h0);

        // Push while full without pop is dropped.
        send(31'hA);
        tick(2);
        chk("drop_ovf",   {31'h0, overflow}, 32'h1);
        chk("drop_level", {28'h0, fifo_level}, 32'h8);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("clr_ovf", {31'h0, overflow}, 32'h0);

        // Drop coinciding with clear leaves overflow set.
        send(31'hB);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("set_wins_ovf", {31'h0, overflow}, 32'h1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;

        // Drain: expect 2..8 then 9.
        for (int i = 0; i < 8; i++)
            pop_chk($sformatf("drain%0d", i));
        chk("drain_level", {28'h0, fifo_level}, 32'h0);
        chk("drain_valid", {31'h0, out_valid}, 32'h0);

        // Pop on empty is ignored.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("empty_pop_level", {28'h0, fifo_level}, 32'h0);

        // Push and pop on the same edge while empty stores the word.
        send(31'h55);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        sb_q.push_back(31'h55);
        chk("empty_pp_level", {28'h0, fifo_level}, 32'h1);
        chk("empty_pp_data",  {1'b0, out_data}, 32'h55);

        // Reset mid-operation with three entries stored.
        send(31'h66);
        send(31'h77);
        tick();
        chk("pre_rst_level", {28'h0, fifo_level}, 32'h3);
        reset_n = 1'b0;
        #1;
        chk("async_rst_level", {28'h0, fifo_level}, 32'h0);
        in_port = 32'h0;
        tog     = 1'b0;
        sb_q.delete();
        tick();
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_data",  {1'b0, out_data}, 32'h0);
        reset_n = 1'b1;
        tick(3);
        chk("post_rst_level", {28'h0, fifo_level}, 32'h0);
        chk("post_rst_valid", {31'h0, out_valid}, 32'h0);

`ifdef NIOS_TX_BRIDGE_DROP_CNT_EN
        chk("dc_reset", {24'h0, drop_count}, 32'h0);
        for (int i = 0; i < 8; i++)
            send(31'(i));
        for (int i = 0; i < 300; i++)
            send(31'(100 + i));
        tick(2);
        chk("dc_sat", {24'h0, drop_count}, 32'd255);
        chk("dc_ovf", {31'h0, overflow}, 32'h1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("dc_clr",     {24'h0, drop_count}, 32'h0);
        chk("dc_clr_ovf", {31'h0, overflow}, 32'h0);
        send(31'h1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("dc_inc_wins", {24'h0, drop_count}, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_tx_bridge.md
NIOS_TX_BRIDGE -- requirements
Module: nios_tx_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, range 2..64.
REQ-002 SHALL have port clk  input  1  rising-edge system clock; same domain as the Nios PIO send port.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_port  input  32  PIO word: bit 31 = message toggle, bits 30:0 = payload.
REQ-005 SHALL have port out_data  output  31  payload at FIFO head.
REQ-006 SHALL have port out_valid  output  1  high while FIFO is non-empty.
REQ-007 SHALL have port out_ready  input  1  consumer accept; a pop occurs when out_valid and out_ready are both high at a rising edge.
REQ-008 SHALL have port fifo_level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-009 SHALL have port overflow  output  1  sticky flag: a message was dropped.
REQ-010 SHALL have port clr_overflow  input  1  synchronous clear for overflow.

Function
REQ-011 SHALL register in_port into in_q on every rising edge, and register in_q[31] into tog_q.
REQ-012 SHALL assert an internal push for one cycle whenever in_q[31] != tog_q; no other condition creates a push.
REQ-013 SHALL write in_q[30:0] into the FIFO on the edge that ends the push cycle, unless the FIFO is full and no pop occurs on that edge.
REQ-014 SHALL have latency as follows: a toggle presented on in_port before edge k makes out_valid high after edge k+1 when the FIFO was empty.
REQ-015 SHALL be show-ahead: out_data SHALL equal the oldest entry whenever out_valid is high; out_data is don't-care when out_valid is low.
REQ-016 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-017 SHALL accept a simultaneous push and pop when full; level is unchanged and no drop occurs.
REQ-018 SHALL accept a simultaneous push and pop when empty; the pop is ignored, the word is stored, and level becomes 1.
REQ-019 SHALL ignore a pop when empty.
REQ-020 SHALL drop the word on a push when full without a pop, leave FIFO contents and level unchanged, and set overflow on that edge.
REQ-021 SHALL let a set of overflow win over a simultaneous clr_overflow.
REQ-022 SHALL wrap read and write pointers modulo DEPTH; level SHALL be derived so that full (level = DEPTH) and empty (level = 0) are unambiguous.
REQ-023 SHALL ignore in_port bits 30:0 changes without a bit-31 change; no push occurs.

Reset
REQ-024 SHALL, while reset_n is low, force in_q=0, tog_q=0, pointers=0, fifo_level=0, out_valid=0, overflow=0, and out_data=0.
REQ-025 SHALL not produce a spurious push after reset release when in_port[31]=0, which is the PIO reset value.
REQ-026 SHALL discard FIFO contents when reset asserts mid-transfer; no partial pop is visible.

Configuration
REQ-027 SHALL, when macro NIOS_TX_BRIDGE_DROP_CNT_EN is defined, add port drop_count  output  8  saturating count of dropped words, reset 0, cleared together with overflow by clr_overflow (an increment wins over a simultaneous clear, leaving the count at 1).
REQ-028 SHALL, without NIOS_TX_BRIDGE_DROP_CNT_EN, omit the drop_count port and its logic entirely; all other behaviour is identical.

Verification
REQ-029 SHALL cover a single message: in_port=0x8000_00AB, out_ready=0 -> out_valid rises 2 edges later, out_data=0x00AB, fifo_level=1; out_ready=1 for 1 cycle -> level 0.
REQ-030 SHALL cover a burst: 8 toggles carrying 1..8 with out_ready=0, DEPTH=8 -> level=8, overflow=0; a 9th toggle -> overflow=1, level=8, and draining yields 1..8 in order.
REQ-031 SHALL cover push and pop together when full: level=8, toggle plus out_ready=1 on the same edge -> level stays 8, overflow stays 0, and the new word is last out.
REQ-032 SHALL cover a payload change without a toggle: in_port 0x0000_0005 -> 0x0000_0007 -> no push, level=0.
REQ-033 SHALL cover reset mid-operation: level=3, reset_n low for 1 cycle -> level=0, out_valid=0, and no push after release with in_port[31]=0.
REQ-034 SHALL cover the drop counter (NIOS_TX_BRIDGE_DROP_CNT_EN defined): 300 drops when full -> drop_count=255; clr_overflow -> drop_count=0 and overflow=0.
